stopwatch_ctrl: RTL and testbench

Control and timekeeping core of the stopwatch. Consumes the single-cycle, clean button pulses produced by the debouncer stage and runs the stopwatch state machine (idle / run / lap / stopped). Maintains a BCD mm:ss.cc time count with its own tick prescaler. Presents either the live count or a frozen lap snapshot to the display driver.

---
 rtl/stopwatch_ctrl.sv | 72 +++++++
 tb/tb_stopwatch_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: stopwatch FSM (idle/run/lap/stopped), tick prescaler and BCD mm:ss.cc count with lap snapshot
// Ports: clk/reset (async, active-high); start_stop_pulse, lap_reset_pulse are one-cycle button events;
// running/lap_active decode the state; cs_bcd/sec_bcd/min_bcd show the snapshot in LAP, else the live count;
// wrap pulses for one cycle after the live count rolls 59:59.99 -> 00:00.00.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop_pulse,
  input  logic       lap_reset_pulse,
  output logic       running,
  output logic       lap_active,
  output logic [7:0] cs_bcd,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic       wrap
);
  localparam int PW = $clog2(TICK_DIV);
  typedef enum logic [1:0] {IDLE, RUN, LAP, STOPPED} state_t;
  state_t state, state_n;
  logic [PW-1:0] presc;
  logic [7:0] cs_q, sec_q, min_q, cs_s, sec_s, min_s, cs_n, sec_n, min_n;
  logic tick, cs_c, sec_c, min_c, clear, capture;
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
  endfunction
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = start_stop_pulse ? RUN : IDLE;
      RUN:     state_n = start_stop_pulse ? STOPPED : lap_reset_pulse ? LAP : RUN;
      LAP:     state_n = start_stop_pulse ? STOPPED : lap_reset_pulse ? RUN : LAP;
      default: state_n = start_stop_pulse ? RUN : lap_reset_pulse ? IDLE : STOPPED;
    endcase
  end
  assign running    = state == RUN || state == LAP;
  assign lap_active = state == LAP;
  assign tick       = running && presc == PW'(TICK_DIV - 1);
  assign clear      = state == STOPPED && state_n == IDLE;
  assign capture    = state == RUN && state_n == LAP;
  assign cs_c       = cs_q == 8'h99;
  assign sec_c      = sec_q == 8'h59;
  assign min_c      = min_q == 8'h59;
  assign cs_n       = cs_c ? 8'h00 : bcd_inc(cs_q);
  assign sec_n      = cs_c ? (sec_c ? 8'h00 : bcd_inc(sec_q)) : sec_q;
  assign min_n      = cs_c && sec_c ? (min_c ? 8'h00 : bcd_inc(min_q)) : min_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      presc <= '0;
      {min_q, sec_q, cs_q} <= '0;
      {min_s, sec_s, cs_s} <= '0;
      wrap  <= 1'b0;
    end else begin
      state <= state_n;
      wrap  <= tick && cs_c && sec_c && min_c;
      if (clear) begin
        presc <= '0;
        {min_q, sec_q, cs_q} <= '0;
      end else if (running) begin
        presc <= tick ? '0 : presc + 1'b1;
        if (tick) {min_q, sec_q, cs_q} <= {min_n, sec_n, cs_n};
      end
      // snapshot takes the pre-edge count, so a coincident tick lands only in the live count
      if (capture) {min_s, sec_s, cs_s} <= {min_q, sec_q, cs_q};
    end
  end
  assign cs_bcd  = lap_active ? cs_s : cs_q;
  assign sec_bcd = lap_active ? sec_s : sec_q;
  assign min_bcd = lap_active ? min_s : min_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: randomized and directed checks of stopwatch_ctrl against a centisecond-total reference model
module tb_stopwatch_ctrl;
  localparam int TD = 4;
  localparam int FULL = 360000;
  logic clk = 0, reset = 1, ss = 0, lr = 0;
  logic running, lap_active, wrap;
  logic [7:0] cs_bcd, sec_bcd, min_bcd;
  logic [26:0] obs;
  int vecs = 0, errs = 0;
  int m_mode, m_phase, m_t, m_snap;
  bit m_wrap;
  stopwatch_ctrl #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .start_stop_pulse(ss), .lap_reset_pulse(lr),
    .running(running), .lap_active(lap_active), .cs_bcd(cs_bcd),
    .sec_bcd(sec_bcd), .min_bcd(min_bcd), .wrap(wrap)
  );
  always #5 clk = ~clk;
  assign obs = {running, lap_active, min_bcd, sec_bcd, cs_bcd, wrap};
  function automatic logic [7:0] bcd2(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction
  function automatic logic [23:0] disp(input int t);
    return {bcd2(t / 6000), bcd2((t / 100) % 60), bcd2(t % 100)};
  endfunction
  function automatic logic [26:0] expv();
    return {m_mode == 1 || m_mode == 2, m_mode == 2, disp(m_mode == 2 ? m_snap : m_t), m_wrap};
  endfunction
  task automatic model_reset();
    m_mode = 0; m_phase = 0; m_t = 0; m_snap = 0; m_wrap = 0;
  endtask
  // modes: 0 idle, 1 run, 2 lap, 3 stopped; time kept as total centiseconds
  task automatic step(input bit s, input bit l);
    int old_t;
    @(negedge clk);
    ss = s; lr = l;
    @(posedge clk);
    old_t = m_t;
    m_wrap = 0;
    if (m_mode == 1 || m_mode == 2) begin
      m_phase++;
      if (m_phase == TD) begin
        m_phase = 0;
        m_wrap = m_t == FULL - 1;
        m_t = (m_t + 1) % FULL;
      end
    end
    if (s) m_mode = (m_mode == 0 || m_mode == 3) ? 1 : 3;
    else if (l) begin
      if (m_mode == 1) begin m_mode = 2; m_snap = old_t; end
      else if (m_mode == 2) m_mode = 1;
      else if (m_mode == 3) begin m_mode = 0; m_t = 0; m_phase = 0; end
    end
    #1;
  endtask
  task automatic test_reset();
    reset = 1;
    #12;
    model_reset();
    vecs++;
    if (obs !== 27'd0) begin errs++; $display("FAIL reset_state got %h want 0", obs); end
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 1);
      vecs++;
      if (obs !== 27'd0 || obs !== expv()) begin errs++; $display("FAIL idle_lap_ignored got %h want 0", obs); end
    end
  endtask
  task automatic test_count();
    step(1, 0);
    vecs++;
    if (running !== 1'b1) begin errs++; $display("FAIL start_running got %b want 1", running); end
    for (int i = 1; i <= 8; i++) begin
      step(0, 0);
      vecs++;
      if (obs !== expv()) begin errs++; $display("FAIL count edge %0d got %h want %h", i, obs, expv()); end
      if (i == 4) begin
        vecs++;
        if (cs_bcd !== 8'h01) begin errs++; $display("FAIL first_tick got %h want 01", cs_bcd); end
      end
      if (i == 8) begin
        vecs++;
        if (cs_bcd !== 8'h02) begin errs++; $display("FAIL second_tick got %h want 02", cs_bcd); end
      end
    end
    for (int i = 0; i < 1000 && m_t != 100; i++) begin
      step(0, 0);
      vecs++;
      if (obs !== expv()) begin errs++; $display("FAIL count_to_sec got %h want %h", obs, expv()); end
    end
    vecs++;
    if ({sec_bcd, cs_bcd} !== 16'h0100) begin errs++; $display("FAIL cs_carry got %h want 0100", {sec_bcd, cs_bcd}); end
  endtask
  task automatic test_wrap();
    force dut.cs_q = 8'h99;
    force dut.sec_q = 8'h59;
    force dut.min_q = 8'h59;
    release dut.cs_q;
    release dut.sec_q;
    release dut.min_q;
    m_t = FULL - 1;
    #1;
    vecs++;
    if (obs !== expv()) begin errs++; $display("FAIL preload got %h want %h", obs, expv()); end
    for (int i = 0; i < 2 * TD && !m_wrap; i++) begin
      step(0, 0);
      vecs++;
      if (obs !== expv()) begin errs++; $display("FAIL wrap_approach got %h want %h", obs, expv()); end
    end
    vecs++;
    if ({wrap, min_bcd, sec_bcd, cs_bcd} !== 25'h1000000) begin
      errs++; $display("FAIL wrap_pulse got %h want 1000000", {wrap, min_bcd, sec_bcd, cs_bcd});
    end
    step(0, 0);
    vecs++;
    if (wrap !== 1'b0 || obs !== expv()) begin errs++; $display("FAIL wrap_one_cycle got %h want %h", obs, expv()); end
  endtask
  task automatic test_lap();
    for (int i = 0; i < 2000 && m_t != 123; i++) step(0, 0);
    step(0, 1);
    vecs++;
    if ({lap_active, min_bcd, sec_bcd, cs_bcd} !== 25'h1000123) begin
      errs++; $display("FAIL lap_enter got %h want 1000123", {lap_active, min_bcd, sec_bcd, cs_bcd});
    end
    for (int i = 0; i < 40; i++) begin
      step(0, 0);
      vecs++;
      if (obs !== expv() || {min_bcd, sec_bcd, cs_bcd} !== 24'h000123) begin
        errs++; $display("FAIL lap_hold got %h want %h", obs, expv());
      end
    end
    step(0, 1);
    vecs++;
    if (lap_active !== 1'b0 || {min_bcd, sec_bcd, cs_bcd} !== 24'h000133 || obs !== expv()) begin
      errs++; $display("FAIL lap_release got %h want %h", obs, expv());
    end
  endtask
  task automatic test_stop_resume();
    int saved;
    for (int i = 0; i < 2 * TD && m_phase != 1; i++) step(0, 0);
    step(1, 0);
    saved = m_t;
    vecs++;
    if (running !== 1'b0 || m_phase != 2) begin errs++; $display("FAIL stop got running=%b want 0", running); end
    for (int i = 0; i < 100; i++) begin
      step(0, 0);
      vecs++;
      if (obs !== expv() || cs_bcd !== bcd2(saved % 100)) begin errs++; $display("FAIL stopped_hold got %h want %h", obs, expv()); end
    end
    step(1, 0);
    step(0, 0);
    vecs++;
    if (cs_bcd !== bcd2(saved % 100) || running !== 1'b1) begin errs++; $display("FAIL resume_early got %h want %h", cs_bcd, bcd2(saved % 100)); end
    step(0, 0);
    vecs++;
    if (cs_bcd !== bcd2((saved + 1) % 100) || obs !== expv()) begin
      errs++; $display("FAIL resume_tick got %h want %h", cs_bcd, bcd2((saved + 1) % 100));
    end
    step(1, 0);
    step(0, 1);
    vecs++;
    if (obs !== 27'd0 || obs !== expv()) begin errs++; $display("FAIL stop_to_idle got %h want 0", obs); end
  endtask
  task automatic test_simultaneous();
    step(1, 0);
    for (int i = 0; i < 6; i++) step(0, 0);
    step(1, 1);
    vecs++;
    if (running !== 1'b0 || lap_active !== 1'b0 || obs !== expv()) begin
      errs++; $display("FAIL simultaneous got %h want %h", obs, expv());
    end
    step(1, 0);
    vecs++;
    if (lap_active !== 1'b0 || obs !== expv()) begin errs++; $display("FAIL simul_resume got %h want %h", obs, expv()); end
  endtask
  task automatic test_async_reset();
    for (int i = 0; i < 4000 && m_t != 540; i++) step(0, 0);
    step(0, 1);
    step(0, 0);
    vecs++;
    if ({lap_active, min_bcd, sec_bcd, cs_bcd} !== 25'h1000540) begin
      errs++; $display("FAIL lap_540 got %h want 1000540", {lap_active, min_bcd, sec_bcd, cs_bcd});
    end
    @(posedge clk);
    #3;
    reset = 1;
    ss = 0;
    lr = 0;
    #1;
    model_reset();
    vecs++;
    if (obs !== 27'd0) begin errs++; $display("FAIL async_reset got %h want 0", obs); end
    @(negedge clk);
    reset = 0;
    step(1, 0);
    for (int i = 0; i < TD; i++) step(0, 0);
    vecs++;
    if ({running, min_bcd, sec_bcd, cs_bcd} !== 25'h1000001 || obs !== expv()) begin
      errs++; $display("FAIL restart got %h want %h", obs, expv());
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0);
      vecs++;
      if (obs !== expv()) begin errs++; $display("FAIL random step %0d got %h want %h", i, obs, expv()); end
    end
  endtask
  initial begin
    model_reset();
    test_reset();
    test_count();
    test_wrap();
    test_lap();
    test_stop_resume();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
